// File: rtl/panda_risc_v_alu_share_arb_if.sv
// Handshake bundle for the shared-ALU arbiter: two request ports and one result slot.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface panda_risc_v_alu_share_arb_if #(
  parameter int TAG_W = 4
);
  logic             s0_req_valid;
  logic             s0_req_ready;
  logic [3:0]       s0_op_mode;
  logic [31:0]      s0_op1;
  logic [31:0]      s0_op2;
  logic [TAG_W-1:0] s0_tag;

  logic             s1_req_valid;
  logic             s1_req_ready;
  logic [3:0]       s1_op_mode;
  logic [31:0]      s1_op1;
  logic [31:0]      s1_op2;
  logic [TAG_W-1:0] s1_tag;

  logic             m_res_valid;
  logic             m_res_ready;
  logic             m_res_id;
  logic [TAG_W-1:0] m_res_tag;
  logic [31:0]      m_res_data;
  logic             m_res_brc;
  logic [31:0]      m_res_ls_addr;

  modport master (
    output s0_req_valid, s0_op_mode, s0_op1, s0_op2, s0_tag,
    input  s0_req_ready,
    output s1_req_valid, s1_op_mode, s1_op1, s1_op2, s1_tag,
    input  s1_req_ready,
    input  m_res_valid, m_res_id, m_res_tag, m_res_data, m_res_brc, m_res_ls_addr,
    output m_res_ready
  );

  modport slave (
    input  s0_req_valid, s0_op_mode, s0_op1, s0_op2, s0_tag,
    output s0_req_ready,
    input  s1_req_valid, s1_op_mode, s1_op1, s1_op2, s1_tag,
    output s1_req_ready,
    output m_res_valid, m_res_id, m_res_tag, m_res_data, m_res_brc, m_res_ls_addr,
    input  m_res_ready
  );
endinterface

// File: rtl/panda_risc_v_alu_share_arb.sv
// Two-requester arbiter in front of one combinational ALU with a 1-entry registered result slot.
// Define PANDA_ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority s0 > s1.
module panda_risc_v_alu_share_arb_alu #(
  parameter EN_SHIFT_REUSE  = "true",
  parameter EN_EQ_CMP_REUSE = "false"
) (
  input  logic [3:0]  op_mode_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output logic [31:0] data_o,
  output logic        brc_o,
  output logic [31:0] ls_addr_o
);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_EQU = 4'd2,  OP_NEQU = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4,  OP_SGE = 4'd5,  OP_ULT = 4'd6,  OP_UGE  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8,  OP_OR  = 4'd9,  OP_AND = 4'd10, OP_SLL  = 4'd11;
  localparam logic [3:0] OP_SRL = 4'd12, OP_SRA = 4'd13;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [31:0] sum;
  logic [32:0] diff;
  logic        ult;
  logic        slt;
  logic        eq;
  logic [4:0]  shamt;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign sum   = op1_i + op2_i;
  assign diff  = {1'b0, op1_i} - {1'b0, op2_i};
  assign ult   = diff[32];
  // Same signs cannot overflow, so the difference sign is the answer.
  assign slt   = (op1_i[31] ^ op2_i[31]) ? op1_i[31] : diff[31];
  assign shamt = op2_i[4:0];

  generate
    if (EN_EQ_CMP_REUSE == "true") begin : g_eq_reuse
      assign eq = (diff[31:0] == 32'd0);
    end else begin : g_eq_direct
      assign eq = (op1_i == op2_i);
    end

    if (EN_SHIFT_REUSE == "true") begin : g_shift_reuse
      // Right shifts run through the left shifter on a bit-reversed operand.
      logic [31:0] sh_in;
      logic [31:0] sh_out;
      logic [31:0] sign_fill;
      assign sh_in     = (op_mode_i == OP_SLL) ? op1_i : rev32(op1_i);
      assign sh_out    = sh_in << shamt;
      assign sign_fill = ~rev32(32'hFFFF_FFFF << shamt) & {32{op1_i[31]}};
      assign sll_res   = sh_out;
      assign srl_res   = rev32(sh_out);
      assign sra_res   = rev32(sh_out) | sign_fill;
    end else begin : g_shift_direct
      assign sll_res = op1_i << shamt;
      assign srl_res = op1_i >> shamt;
      assign sra_res = $unsigned($signed(op1_i) >>> shamt);
    end
  endgenerate

  assign ls_addr_o = sum;

  always_comb begin
    data_o = 32'd0;
    brc_o  = ult;
    unique case (op_mode_i)
      OP_ADD:  data_o = sum;
      OP_SUB:  data_o = diff[31:0];
      OP_EQU:  begin brc_o = eq;   data_o = {31'd0, eq};   end
      OP_NEQU: begin brc_o = ~eq;  data_o = {31'd0, ~eq};  end
      OP_SLT:  begin brc_o = slt;  data_o = {31'd0, slt};  end
      OP_SGE:  begin brc_o = ~slt; data_o = {31'd0, ~slt}; end
      OP_ULT:  begin brc_o = ult;  data_o = {31'd0, ult};  end
      OP_UGE:  begin brc_o = ~ult; data_o = {31'd0, ~ult}; end
      OP_XOR:  data_o = op1_i ^ op2_i;
      OP_OR:   data_o = op1_i | op2_i;
      OP_AND:  data_o = op1_i & op2_i;
      OP_SLL:  data_o = sll_res;
      OP_SRL:  data_o = srl_res;
      OP_SRA:  data_o = sra_res;
      default: data_o = 32'd0;
    endcase
  end
endmodule

module panda_risc_v_alu_share_arb #(
  parameter     EN_SHIFT_REUSE  = "true",
  parameter     EN_EQ_CMP_REUSE = "false",
  parameter int TAG_W           = 4,
  parameter int SIM_DELAY       = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  panda_risc_v_alu_share_arb_if.slave   bus
);
  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_data;
  logic        alu_brc;
  logic [31:0] alu_ls_addr;

  logic             res_valid_q,   res_valid_d;
  logic             res_id_q,      res_id_d;
  logic [TAG_W-1:0] res_tag_q,     res_tag_d;
  logic [31:0]      res_data_q,    res_data_d;
  logic             res_brc_q,     res_brc_d;
  logic [31:0]      res_ls_addr_q, res_ls_addr_d;

  assign slot_free = ~res_valid_q | bus.m_res_ready;

`ifdef PANDA_ALU_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  // Under contention the requester that did not win last time goes first.
  assign grant0 = bus.s0_req_valid & (~bus.s1_req_valid | last_grant_q);
  assign grant1 = bus.s1_req_valid & (~bus.s0_req_valid | ~last_grant_q);
  assign last_grant_d = accept ? grant1 : last_grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_grant_q <= 1'b1;
    else         last_grant_q <= last_grant_d;
  end
`else
  assign grant0 = bus.s0_req_valid;
  assign grant1 = bus.s1_req_valid & ~bus.s0_req_valid;
`endif

  assign bus.s0_req_ready = slot_free & grant0;
  assign bus.s1_req_ready = slot_free & grant1;
  assign accept           = slot_free & (grant0 | grant1);

  assign alu_op  = grant1 ? bus.s1_op_mode : bus.s0_op_mode;
  assign alu_op1 = grant1 ? bus.s1_op1     : bus.s0_op1;
  assign alu_op2 = grant1 ? bus.s1_op2     : bus.s0_op2;

  panda_risc_v_alu_share_arb_alu #(
    .EN_SHIFT_REUSE  (EN_SHIFT_REUSE),
    .EN_EQ_CMP_REUSE (EN_EQ_CMP_REUSE)
  ) u_alu (
    .op_mode_i (alu_op),
    .op1_i     (alu_op1),
    .op2_i     (alu_op2),
    .data_o    (alu_data),
    .brc_o     (alu_brc),
    .ls_addr_o (alu_ls_addr)
  );

  always_comb begin
    res_valid_d   = res_valid_q;
    res_id_d      = res_id_q;
    res_tag_d     = res_tag_q;
    res_data_d    = res_data_q;
    res_brc_d     = res_brc_q;
    res_ls_addr_d = res_ls_addr_q;
    if (accept) begin
      res_valid_d   = 1'b1;
      res_id_d      = grant1;
      res_tag_d     = grant1 ? bus.s1_tag : bus.s0_tag;
      res_data_d    = alu_data;
      res_brc_d     = alu_brc;
      res_ls_addr_d = alu_ls_addr;
    end else if (bus.m_res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // SIM_DELAY only shapes simulation timing elsewhere; the slot registers are unconditional.
  generate
    if (SIM_DELAY >= 0) begin : g_slot
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          res_valid_q   <= 1'b0;
          res_id_q      <= 1'b0;
          res_tag_q     <= '0;
          res_data_q    <= 32'd0;
          res_brc_q     <= 1'b0;
          res_ls_addr_q <= 32'd0;
        end else begin
          res_valid_q   <= res_valid_d;
          res_id_q      <= res_id_d;
          res_tag_q     <= res_tag_d;
          res_data_q    <= res_data_d;
          res_brc_q     <= res_brc_d;
          res_ls_addr_q <= res_ls_addr_d;
        end
      end
    end
  endgenerate

  assign bus.m_res_valid   = res_valid_q;
  assign bus.m_res_id      = res_id_q;
  assign bus.m_res_tag     = res_tag_q;
  assign bus.m_res_data    = res_data_q;
  assign bus.m_res_brc     = res_brc_q;
  assign bus.m_res_ls_addr = res_ls_addr_q;
endmodule

// File: tb/tb_panda_risc_v_alu_share_arb.sv
// Directed-vector bench for panda_risc_v_alu_share_arb; expectations follow PANDA_ALU_ARB_RR_EN.
module tb_panda_risc_v_alu_share_arb;
  typedef struct {
    logic        sel;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        brc;
    logic [31:0] ls;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;
  vec_t vecs[17];

  panda_risc_v_alu_share_arb_if #(.TAG_W(4)) bus ();

  panda_risc_v_alu_share_arb #(.TAG_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    if (n == 0) begin
      bus.s0_req_valid = v; bus.s0_op_mode = op; bus.s0_op1 = a; bus.s0_op2 = b; bus.s0_tag = tag;
    end else begin
      bus.s1_req_valid = v; bus.s1_op_mode = op; bus.s1_op1 = a; bus.s1_op2 = b; bus.s1_tag = tag;
    end
  endtask

  task automatic chk_res(input string nm, input logic v, input logic id, input logic [3:0] tag,
                         input logic [31:0] data);
    chk({nm, ".valid"}, 32'(bus.m_res_valid), 32'(v));
    chk({nm, ".id"},    32'(bus.m_res_id),    32'(id));
    chk({nm, ".tag"},   32'(bus.m_res_tag),   32'(tag));
    chk({nm, ".data"},  bus.m_res_data,       data);
  endtask

  initial begin
    logic        rr;
    logic        exp_id;
    logic [31:0] exp_data;
    logic [3:0]  exp_tag;
`ifdef PANDA_ALU_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    n_cmp = 0;
    n_err = 0;

    vecs[0]  = '{1'b0, 4'd0,  32'd5,          32'd7,          4'd3, 32'd12,         1'b1, 32'd12};
    vecs[1]  = '{1'b1, 4'd13, 32'h8000_0000,  32'd4,          4'd5, 32'hF800_0000,  1'b0, 32'h8000_0004};
    vecs[2]  = '{1'b0, 4'd4,  32'hFFFF_FFFF,  32'd1,          4'd1, 32'd1,          1'b1, 32'd0};
    vecs[3]  = '{1'b0, 4'd7,  32'hFFFF_FFFF,  32'd1,          4'd2, 32'd1,          1'b1, 32'd0};
    vecs[4]  = '{1'b1, 4'd1,  32'd10,         32'd3,          4'd6, 32'd7,          1'b0, 32'd13};
    vecs[5]  = '{1'b0, 4'd11, 32'd1,          32'd31,         4'd7, 32'h8000_0000,  1'b1, 32'd32};
    vecs[6]  = '{1'b1, 4'd12, 32'h8000_0000,  32'd31,         4'd8, 32'd1,          1'b0, 32'h8000_001F};
    vecs[7]  = '{1'b0, 4'd8,  32'hF0F0_F0F0,  32'hFF00_FF00,  4'd9, 32'h0FF0_0FF0,  1'b1, 32'hEFF1_EFF0};
    vecs[8]  = '{1'b1, 4'd2,  32'd7,          32'd7,          4'hA, 32'd1,          1'b1, 32'd14};
    vecs[9]  = '{1'b0, 4'd3,  32'd7,          32'd7,          4'hB, 32'd0,          1'b0, 32'd14};
    vecs[10] = '{1'b0, 4'd14, 32'd2,          32'd3,          4'hC, 32'd0,          1'b1, 32'd5};
    vecs[11] = '{1'b1, 4'd15, 32'd9,          32'd3,          4'hD, 32'd0,          1'b0, 32'd12};
    vecs[12] = '{1'b0, 4'd5,  32'h8000_0000,  32'd1,          4'hE, 32'd0,          1'b0, 32'h8000_0001};
    vecs[13] = '{1'b1, 4'd6,  32'd1,          32'd2,          4'hF, 32'd1,          1'b1, 32'd3};
    vecs[14] = '{1'b0, 4'd10, 32'hFF00_FF00,  32'h0F0F_0F0F,  4'd0, 32'h0F00_0F00,  1'b0, 32'h0E10_0E0F};
    vecs[15] = '{1'b1, 4'd9,  32'h0000_0F00,  32'h0000_00F0,  4'd1, 32'h0000_0FF0,  1'b0, 32'h0000_0FF0};
    vecs[16] = '{1'b0, 4'd13, 32'h4000_0000,  32'd4,          4'd2, 32'h0400_0000,  1'b0, 32'h4000_0004};

    // Reset held with both requesters valid.
    resetn = 1'b0;
    bus.m_res_ready = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1, 4'hA);
    set_req(1, 1'b1, 4'd0, 32'd2, 32'd2, 4'hB);
    tick(); tick(); tick();
    chk_res("reset", 1'b0, 1'b0, 4'd0, 32'd0);
    chk("reset.brc", 32'(bus.m_res_brc), 32'd0);
    chk("reset.ls_addr", bus.m_res_ls_addr, 32'd0);
    resetn = 1'b1;

    // Contention with the consumer always ready.
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_id   = rr ? c[0] : 1'b0;
      exp_tag  = exp_id ? 4'hB : 4'hA;
      exp_data = exp_id ? 32'd4 : 32'd2;
      chk_res($sformatf("contend%0d", c), 1'b1, exp_id, exp_tag, exp_data);
    end
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    tick();

    // Single-requester vectors, back to back; the idle side carries junk operands.
    for (int i = 0; i < 17; i++) begin
      set_req(vecs[i].sel ? 1 : 0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      set_req(vecs[i].sel ? 0 : 1, 1'b0, 4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 4'd15);
      #1;
      chk($sformatf("vec%0d.ready", i),
          32'(vecs[i].sel ? bus.s1_req_ready : bus.s0_req_ready), 32'd1);
      tick();
      chk_res($sformatf("vec%0d", i), 1'b1, vecs[i].sel, vecs[i].tag, vecs[i].data);
      chk($sformatf("vec%0d.brc", i), 32'(bus.m_res_brc), 32'(vecs[i].brc));
      chk($sformatf("vec%0d.ls_addr", i), bus.m_res_ls_addr, vecs[i].ls);
    end

    // Drain with no new accept: valid drops, data holds.
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    tick();
    chk_res("drain", 1'b0, 1'b0, 4'd2, 32'h0400_0000);

    // Stall for 3 cycles, then accept on the same edge the consumer drains.
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd2, 4'd4);
    tick();
    chk_res("stall.pre", 1'b1, 1'b0, 4'd4, 32'd3);
    bus.m_res_ready = 1'b0;
    set_req(0, 1'b1, 4'd0, 32'd10, 32'd20, 4'd6);
    set_req(1, 1'b1, 4'd1, 32'd9,  32'd4,  4'd7);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.s0_ready", c), 32'(bus.s0_req_ready), 32'd0);
      chk($sformatf("stall%0d.s1_ready", c), 32'(bus.s1_req_ready), 32'd0);
      tick();
      chk_res($sformatf("stall%0d", c), 1'b1, 1'b0, 4'd4, 32'd3);
    end
    bus.m_res_ready = 1'b1;
    #1;
    chk("resume.s0_ready", 32'(bus.s0_req_ready), 32'(!rr));
    chk("resume.s1_ready", 32'(bus.s1_req_ready), 32'(rr));
    tick();
    if (rr) chk_res("resume", 1'b1, 1'b1, 4'd7, 32'd5);
    else    chk_res("resume", 1'b1, 1'b0, 4'd6, 32'd30);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    tick();
    chk("idle.valid", 32'(bus.m_res_valid), 32'd0);

    // Reset asserted in the middle of a stall.
    set_req(0, 1'b1, 4'd0, 32'd100, 32'd1, 4'd2);
    tick();
    chk_res("rst_stall.pre", 1'b1, 1'b0, 4'd2, 32'd101);
    bus.m_res_ready = 1'b0;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    #3;
    resetn = 1'b0;
    #1;
    chk_res("rst_stall.async", 1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    resetn = 1'b1;
    bus.m_res_ready = 1'b1;
    tick();
    chk("rst_stall.stale0", 32'(bus.m_res_valid), 32'd0);
    tick();
    chk("rst_stall.stale1", 32'(bus.m_res_valid), 32'd0);
    set_req(0, 1'b1, 4'd0, 32'd3, 32'd4, 4'd9);
    tick();
    chk_res("rst_stall.post", 1'b1, 1'b0, 4'd9, 32'd7);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
